// File: rtl/aircon_pkg.sv
// Shared encodings for the air-conditioner controller: modes, levels, fan duties and
// sequencer state codes.
package aircon_pkg;

  localparam logic [1:0] ModeIdle   = 2'd0;
  localparam logic [1:0] ModeAuto   = 2'd1;
  localparam logic [1:0] ModeManual = 2'd2;

  localparam logic [1:0] Level0 = 2'd0;
  localparam logic [1:0] Level1 = 2'd1;
  localparam logic [1:0] Level2 = 2'd2;
  localparam logic [1:0] Level3 = 2'd3;

  localparam logic [7:0] DutyOff     = 8'd0;
  localparam logic [7:0] DutyLevel0  = 8'd64;
  localparam logic [7:0] DutyLevel1  = 8'd128;
  localparam logic [7:0] DutyLevel2  = 8'd192;
  localparam logic [7:0] DutyLevel3  = 8'd255;
  localparam logic [7:0] DutyPostrun = 8'd64;

  localparam logic [2:0] StOff      = 3'd0;
  localparam logic [2:0] StPrestart = 3'd1;
  localparam logic [2:0] StFanOnly  = 3'd2;
  localparam logic [2:0] StRun      = 3'd3;
  localparam logic [2:0] StPostrun  = 3'd4;

  function automatic logic [7:0] duty_for_level(logic [1:0] lvl);
    logic [7:0] d;
    unique case (lvl)
      Level0:  d = DutyLevel0;
      Level1:  d = DutyLevel1;
      Level2:  d = DutyLevel2;
      default: d = DutyLevel3;
    endcase
    return d;
  endfunction

  // Decrement on tick, holding at zero.
  function automatic logic [7:0] sat_dec(logic [7:0] c, logic en);
    return (en && (c != 8'd0)) ? c - 8'd1 : c;
  endfunction

endpackage

// File: rtl/fan_ramp_pwm.sv
// Fan duty ramp (one step per tick, clamped at the target) and free-running 8-bit PWM.
module fan_ramp_pwm
  import aircon_pkg::*;
#(
  parameter int unsigned RAMP_STEP = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick,
  input  logic [7:0] target,
  output logic [7:0] fan_duty,
  output logic       fan_pwm
);

  logic [7:0] duty_q, duty_d;
  logic [7:0] pwm_cnt_q;
  logic [8:0] step9, up_sum, dn_diff, target9;

  assign step9   = 9'(RAMP_STEP);
  assign target9 = {1'b0, target};
  assign up_sum  = {1'b0, duty_q} + step9;
  assign dn_diff = {1'b0, duty_q} - step9;

  always_comb begin
    duty_d = duty_q;
    if (tick) begin
      if (duty_q < target) begin
        duty_d = (up_sum > target9) ? target : up_sum[7:0];
      end else if (duty_q > target) begin
        // Borrow in bit 8 means the step ran below zero.
        duty_d = (dn_diff[8] || (dn_diff < target9)) ? target : dn_diff[7:0];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      duty_q    <= DutyOff;
      pwm_cnt_q <= 8'd0;
    end else begin
      duty_q    <= duty_d;
      pwm_cnt_q <= pwm_cnt_q + 8'd1;
    end
  end

  assign fan_duty = duty_q;
  assign fan_pwm  = (pwm_cnt_q < duty_q);

endmodule

// File: rtl/climate_sequencer.sv
// Actuator sequencer: fan prestart, compressor lockout, safe valve changeover and
// fan post-run, driving a ramped fan PWM.
module climate_sequencer
  import aircon_pkg::*;
#(
  parameter int unsigned MIN_OFF_S  = 3,
  parameter int unsigned PRESTART_S = 2,
  parameter int unsigned POSTRUN_S  = 5,
  parameter int unsigned RAMP_STEP  = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick,
  input  logic [1:0] mode,
  input  logic       heat_cool,
  input  logic [1:0] level,
  input  logic       ultrasonic_mode,
  output logic       compressor_on,
  output logic       valve_cool,
  output logic       fan_pwm,
  output logic [7:0] fan_duty,
  output logic       humidifier_en,
  output logic [2:0] state
);

  logic [2:0] state_q, state_d;
  logic       valve_q, valve_d;
  logic [7:0] prestart_q, prestart_d;
  logic [7:0] postrun_q, postrun_d;
  logic [7:0] lockout_q, lockout_d;
  logic [7:0] target;
  logic       idle, demand, can_run;

  // Mode code 3 is reserved and behaves as IDLE.
  assign idle    = (mode == ModeIdle) || (mode == 2'd3);
  assign demand  = (mode == ModeManual) || ((mode == ModeAuto) && (level != Level0));
  assign can_run = demand && (lockout_q == 8'd0);

  always_comb begin
    state_d    = state_q;
    valve_d    = valve_q;
    prestart_d = sat_dec(prestart_q, tick);
    postrun_d  = sat_dec(postrun_q, tick);
    lockout_d  = sat_dec(lockout_q, tick);
    case (state_q)
      StOff: begin
        if (!idle) begin
          state_d    = StPrestart;
          prestart_d = 8'(PRESTART_S);
        end
      end
      StPrestart: begin
        if (idle) begin
          state_d   = StPostrun;
          postrun_d = 8'(POSTRUN_S);
        end else if (prestart_q == 8'd0) begin
          state_d = can_run ? StRun : StFanOnly;
          if (can_run) valve_d = heat_cool;
        end
      end
      StFanOnly: begin
        if (idle) begin
          state_d   = StPostrun;
          postrun_d = 8'(POSTRUN_S);
        end else if (can_run) begin
          state_d = StRun;
          valve_d = heat_cool;
        end
      end
      StRun: begin
        if (idle) begin
          state_d   = StPostrun;
          postrun_d = 8'(POSTRUN_S);
          lockout_d = 8'(MIN_OFF_S);
        end else if (!demand || (heat_cool != valve_q)) begin
          state_d   = StFanOnly;
          lockout_d = 8'(MIN_OFF_S);
        end
      end
      StPostrun: begin
        if (!idle) begin
          state_d = StFanOnly;
        end else if (postrun_q == 8'd0) begin
          state_d = StOff;
        end
      end
      default: state_d = StOff;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= StOff;
      valve_q    <= 1'b0;
      prestart_q <= 8'd0;
      postrun_q  <= 8'd0;
      lockout_q  <= 8'd0;
    end else begin
      state_q    <= state_d;
      valve_q    <= valve_d;
      prestart_q <= prestart_d;
      postrun_q  <= postrun_d;
      lockout_q  <= lockout_d;
    end
  end

  always_comb begin
    case (state_q)
      StOff:     target = DutyOff;
      StPostrun: target = DutyPostrun;
      default:   target = duty_for_level(level);
    endcase
  end

  fan_ramp_pwm #(
    .RAMP_STEP(RAMP_STEP)
  ) u_fan (
    .clk     (clk),
    .reset   (reset),
    .tick    (tick),
    .target  (target),
    .fan_duty(fan_duty),
    .fan_pwm (fan_pwm)
  );

  assign compressor_on = (state_q == StRun);
  assign valve_cool    = valve_q;
  assign state         = state_q;
  assign humidifier_en = ultrasonic_mode && ((state_q == StFanOnly) || (state_q == StRun));

endmodule

// File: tb/tb_climate_sequencer.sv
// Directed bench for climate_sequencer: a per-cycle vector table for the sequencing
// scenarios, then hand-written ramp, PWM and reset sequences.
module tb_climate_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic       tick;
  logic [1:0] mode;
  logic       heat_cool;
  logic [1:0] level;
  logic       ultrasonic_mode;
  logic       compressor_on;
  logic       valve_cool;
  logic       fan_pwm;
  logic [7:0] fan_duty;
  logic       humidifier_en;
  logic [2:0] state;

  int n_checks = 0;
  int n_fail   = 0;

  climate_sequencer dut (
    .clk            (clk),
    .reset          (reset),
    .tick           (tick),
    .mode           (mode),
    .heat_cool      (heat_cool),
    .level          (level),
    .ultrasonic_mode(ultrasonic_mode),
    .compressor_on  (compressor_on),
    .valve_cool     (valve_cool),
    .fan_pwm        (fan_pwm),
    .fan_duty       (fan_duty),
    .humidifier_en  (humidifier_en),
    .state          (state)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] mode;
    logic [1:0] level;
    logic       hc;
    logic       us;
    logic       tk;
    logic [2:0] st;
    logic       comp;
    logic       valve;
    logic       hum;
    logic [7:0] duty;
  } vec_t;

  localparam int NVec = 28;
  vec_t vecs[NVec];

  function automatic vec_t mk(logic [1:0] m, logic [1:0] l, logic h, logic u, logic t,
                              logic [2:0] s, logic c, logic v, logic hu, logic [7:0] d);
    vec_t r;
    r.mode = m; r.level = l; r.hc = h; r.us = u; r.tk = t;
    r.st = s; r.comp = c; r.valve = v; r.hum = hu; r.duty = d;
    return r;
  endfunction

  task automatic check(input string name, input int actual, input int expected);
    n_checks++;
    if (actual != expected) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic tick_cycle();
    tick = 1'b1;
    @(negedge clk);
    tick = 1'b0;
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic count_pwm(output int highs);
    highs = 0;
    for (int i = 0; i < 256; i++) begin
      @(negedge clk);
      if (fan_pwm) highs++;
    end
  endtask

  initial begin
    int first_hit;
    int bad_steps;
    int prev;
    int highs;

    // mode, level, hc, us, tick | state, comp, valve, hum, duty
    vecs[0]  = mk(1, 2, 1, 1, 0, 1, 0, 0, 0, 0);   // OFF -> PRESTART
    vecs[1]  = mk(1, 2, 1, 1, 1, 1, 0, 0, 0, 8);
    vecs[2]  = mk(1, 2, 1, 1, 1, 1, 0, 0, 0, 16);
    vecs[3]  = mk(1, 2, 1, 1, 0, 3, 1, 1, 1, 16);  // prestart done -> RUN, valve cool
    vecs[4]  = mk(1, 0, 1, 1, 1, 2, 0, 1, 1, 24);  // short cycle: demand drops
    vecs[5]  = mk(1, 2, 1, 1, 0, 2, 0, 1, 1, 24);  // demand back, lockout 3
    vecs[6]  = mk(1, 2, 1, 1, 1, 2, 0, 1, 1, 32);
    vecs[7]  = mk(1, 2, 1, 1, 1, 2, 0, 1, 1, 40);
    vecs[8]  = mk(1, 2, 1, 1, 1, 2, 0, 1, 1, 48);
    vecs[9]  = mk(1, 2, 1, 1, 0, 3, 1, 1, 1, 48);  // lockout expired -> RUN
    vecs[10] = mk(1, 2, 0, 1, 0, 2, 0, 1, 1, 48);  // changeover request
    vecs[11] = mk(1, 2, 0, 1, 1, 2, 0, 1, 1, 56);
    vecs[12] = mk(1, 2, 0, 1, 1, 2, 0, 1, 1, 64);
    vecs[13] = mk(1, 2, 0, 1, 1, 2, 0, 1, 1, 72);
    vecs[14] = mk(1, 2, 0, 1, 0, 3, 1, 0, 1, 72);  // RUN heating, valve switched
    vecs[15] = mk(0, 2, 0, 1, 0, 4, 0, 0, 0, 72);  // shutdown -> POSTRUN
    vecs[16] = mk(0, 2, 0, 1, 1, 4, 0, 0, 0, 64);
    vecs[17] = mk(0, 2, 0, 1, 1, 4, 0, 0, 0, 64);
    vecs[18] = mk(1, 2, 0, 1, 1, 2, 0, 0, 1, 64);  // AUTO during POSTRUN -> FAN_ONLY
    vecs[19] = mk(0, 2, 0, 1, 0, 4, 0, 0, 0, 64);
    vecs[20] = mk(0, 2, 0, 1, 1, 4, 0, 0, 0, 64);
    vecs[21] = mk(0, 2, 0, 1, 1, 4, 0, 0, 0, 64);
    vecs[22] = mk(0, 2, 0, 1, 1, 4, 0, 0, 0, 64);
    vecs[23] = mk(0, 2, 0, 1, 1, 4, 0, 0, 0, 64);
    vecs[24] = mk(0, 2, 0, 1, 1, 4, 0, 0, 0, 64);
    vecs[25] = mk(0, 2, 0, 1, 0, 0, 0, 0, 0, 64);  // postrun expired -> OFF
    vecs[26] = mk(0, 2, 0, 1, 1, 0, 0, 0, 0, 56);
    vecs[27] = mk(3, 2, 0, 1, 0, 0, 0, 0, 0, 56);  // mode 3 stays OFF

    tick = 1'b0; mode = 2'd0; heat_cool = 1'b0; level = 2'd0; ultrasonic_mode = 1'b0;
    reset = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("reset state", int'(state), 0);
    check("reset compressor", int'(compressor_on), 0);
    check("reset valve", int'(valve_cool), 0);
    check("reset duty", int'(fan_duty), 0);
    check("reset pwm", int'(fan_pwm), 0);
    check("reset humidifier", int'(humidifier_en), 0);
    reset = 1'b1;
    @(negedge clk);

    for (int i = 0; i < NVec; i++) begin
      mode = vecs[i].mode; level = vecs[i].level; heat_cool = vecs[i].hc;
      ultrasonic_mode = vecs[i].us; tick = vecs[i].tk;
      @(negedge clk);
      tick = 1'b0;
      check($sformatf("vec%0d state", i), int'(state), int'(vecs[i].st));
      check($sformatf("vec%0d compressor", i), int'(compressor_on), int'(vecs[i].comp));
      check($sformatf("vec%0d valve", i), int'(valve_cool), int'(vecs[i].valve));
      check($sformatf("vec%0d humidifier", i), int'(humidifier_en), int'(vecs[i].hum));
      check($sformatf("vec%0d duty", i), int'(fan_duty), int'(vecs[i].duty));
    end

    // Cold start ramp 0 -> 192 in steps of 8.
    do_reset();
    mode = 2'd1; level = 2'd2; heat_cool = 1'b1; ultrasonic_mode = 1'b1;
    @(negedge clk);
    first_hit = -1; bad_steps = 0; prev = 0;
    for (int t = 1; t <= 30; t++) begin
      tick_cycle();
      if (prev < 192 && int'(fan_duty) != prev + 8) bad_steps++;
      if (prev == 192 && int'(fan_duty) != 192) bad_steps++;
      if (first_hit < 0 && fan_duty == 8'd192) first_hit = t;
      prev = int'(fan_duty);
    end
    check("ramp up step errors", bad_steps, 0);
    check("ramp up ticks to 192", first_hit, 24);
    check("cold start state", int'(state), 3);
    check("cold start valve", int'(valve_cool), 1);

    // Level 0 drops demand: FAN_ONLY at duty 64, PWM duty 64/256.
    level = 2'd0;
    for (int t = 0; t < 20; t++) tick_cycle();
    check("fan-only state", int'(state), 2);
    check("fan-only humidifier", int'(humidifier_en), 1);
    check("fan-only duty", int'(fan_duty), 64);
    count_pwm(highs);
    check("pwm highs at 64", highs, 64);

    // MANUAL level 3: saturate at 255 and run.
    mode = 2'd2; level = 2'd3;
    for (int t = 0; t < 30; t++) tick_cycle();
    check("manual duty saturates", int'(fan_duty), 255);
    check("manual state", int'(state), 3);
    check("manual compressor", int'(compressor_on), 1);
    count_pwm(highs);
    check("pwm highs at 255", highs, 255);

    // Asynchronous reset mid-RUN, then restart without lockout.
    #2 reset = 1'b0;
    #1;
    check("async reset compressor", int'(compressor_on), 0);
    check("async reset state", int'(state), 0);
    check("async reset duty", int'(fan_duty), 0);
    check("async reset valve", int'(valve_cool), 0);
    check("async reset humidifier", int'(humidifier_en), 0);
    check("async reset pwm", int'(fan_pwm), 0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("restart prestart", int'(state), 1);
    tick_cycle();
    check("restart prestart held", int'(state), 1);
    tick_cycle();
    check("restart run", int'(state), 3);
    check("restart compressor", int'(compressor_on), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/climate_sequencer.md
# climate_sequencer

Sequences the air-conditioner actuators from the button controller's mode, heat/cool and comfort-level outputs. It enforces fan prestart, compressor anti-short-cycle lockout, safe reversing-valve changeover and fan post-run, and ramps the fan PWM duty. It sits between the button controller and the fan/compressor/humidifier drive pins.

## Interface
- MIN_OFF_S, 3: compressor minimum off time, in ticks
- PRESTART_S, 2: fan-only time before the first compressor start, in ticks
- POSTRUN_S, 5: fan run-on after IDLE is requested, in ticks
- RAMP_STEP, 8: fan duty change per tick
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset (0 = reset)
- tick  in  1  one-clk-wide timebase pulse (nominally 1 Hz)
- mode  in  2  0 IDLE, 1 AUTO, 2 MANUAL, 3 treated as IDLE
- heat_cool  in  1  requested direction: 1 cool, 0 heat
- level  in  2  comfort level 0..3 (0 = comfortable)
- ultrasonic_mode  in  1  humidifier requested
- compressor_on  out  1  compressor drive
- valve_cool  out  1  reversing valve: 1 cool, 0 heat
- fan_pwm  out  1  fan PWM
- fan_duty  out  8  current (ramped) duty
- humidifier_en  out  1  humidifier drive
- state  out  3  FSM state, for display and debug

## Operation
- Demand: AUTO → level != 0. MANUAL → always. IDLE → never.
- Duty target by level: 0 → 64, 1 → 128, 2 → 192, 3 → 255. POSTRUN target is 64. OFF target is 0.
- States and their outputs:
  - OFF: compressor 0, target 0.
  - PRESTART: compressor 0, target from the table.
  - FAN_ONLY: compressor 0, target from the table.
  - RUN: compressor 1, target from the table.
  - POSTRUN: compressor 0, target 64.
- Transitions, evaluated in priority order:
  - OFF: mode != IDLE → PRESTART, and the prestart counter loads PRESTART_S.
  - PRESTART: mode IDLE → POSTRUN. When the prestart counter reaches 0: demand && lockout==0 → RUN, otherwise → FAN_ONLY.
  - FAN_ONLY: mode IDLE → POSTRUN. demand && lockout==0 → RUN.
  - RUN: mode IDLE → POSTRUN. !demand or heat_cool != valve_cool → FAN_ONLY.
  - POSTRUN: mode != IDLE → FAN_ONLY. Counter reaches 0 → OFF. The counter loads POSTRUN_S on entry.
- Lockout counter:
  - Loads MIN_OFF_S on every exit from RUN.
  - Decrements on tick, saturating at 0.
  - RUN is entered only with lockout==0.
- valve_cool loads heat_cool only on a transition into RUN, so the valve never changes while the compressor is on. A direction change while in RUN forces a full lockout before restart.
- humidifier_en = ultrasonic_mode && state ∈ {FAN_ONLY, RUN}.
- Fan ramp:
  - On tick, fan_duty moves toward the target by RAMP_STEP.
  - Clamp at the target: no overshoot, no wrap. Compute the step in 9 bits and saturate to 0..255.
- PWM:
  - 8-bit counter, free-running on clk, wraps 255 → 0.
  - fan_pwm = (pwm_cnt < fan_duty). Duty 0 gives constant 0. Duty 255 is high 255 of every 256 clk.

## Timing
- Reset: all outputs 0. State OFF, every counter 0, pwm_cnt 0.
- Reset asserted mid-operation: compressor_on drops asynchronously in the same cycle. No lockout is enforced after reset release.
- State registers update on the clk edge after the condition holds, giving 1-cycle input-to-output latency.
- Counters change only on tick cycles. A counter reaching 0 on a tick causes its transition on the following clk.
- tick and a mode change in the same cycle: the transition priority above applies, and the counter still decrements.
- Lockout and prestart count concurrently: RUN needs both at 0.
- The ramp steps at most once per tick, independent of state changes in that cycle.

## Structure
- Shared package `aircon_pkg` holds:
  - mode codes (IDLE/AUTO/MANUAL), the level codes, and the duty table constants;
  - the state encoding: OFF=0, PRESTART=1, FAN_ONLY=2, RUN=3, POSTRUN=4.
- The `btn_controller` encodings must match these package constants.
- One sub-module, `fan_ramp_pwm`:
  - inputs: clk, reset, tick, target, RAMP_STEP;
  - outputs: fan_duty, fan_pwm.
- The FSM and its counters stay in the top level.

## Test plan
- **Cold start:** mode=AUTO, level=2, heat_cool=1. Required: PRESTART for 2 ticks, then RUN with compressor_on=1 and valve_cool=1. fan_duty ramps 0 → 192 in steps of 8 over 24 ticks.
- **Short-cycle:** in RUN, level 2 → 0 → 2 within 1 tick. Required: FAN_ONLY immediately. compressor_on stays 0 until 3 ticks have elapsed, then RUN.
- **Changeover:** in RUN with valve_cool=1, heat_cool → 0. Required: compressor off, valve_cool stays 1 for the 3-tick lockout, then RUN with valve_cool=0. The valve never changes while compressor_on=1.
- **Shutdown:** in RUN, mode → IDLE. Required: POSTRUN with compressor 0 and duty ramping toward 64, OFF after 5 ticks, then duty ramps to 0. Re-entering AUTO during POSTRUN → FAN_ONLY.
- **Humidifier and PWM:** ultrasonic_mode=1 in OFF → humidifier_en=0; in FAN_ONLY → 1. At duty 64, fan_pwm is high exactly 64 of 256 clk.
- **Reset:** reset=0 mid-RUN. Required: all outputs 0 immediately. After release with mode=MANUAL, the sequence restarts through PRESTART.
